// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one FPU among NREQ requesters, one op in flight.
// Optional sticky per-requester exception flags: define FPU_ARB_STICKY_FSR_EN.
module fpu_arbiter #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int LAT_SHORT = 1,
  parameter int LAT_LONG  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [3:0]           fpu_op_sel,
  output logic [31:0]          fpu_rsA,
  output logic [31:0]          fpu_rsB,
  input  logic [31:0]          fpu_rd,
  input  logic [4:0]           fpu_exc,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [31:0]          resp_data,
  output logic [4:0]           resp_exc,
  output logic [5*NREQ-1:0]    fsr_flags,
  input  logic [NREQ-1:0]      fsr_clr
);

  localparam int LATMAX = (LAT_LONG > LAT_SHORT) ? LAT_LONG : LAT_SHORT;
  localparam int CNTW   = $clog2(LATMAX + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, next_state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] cand_id;
  logic           cand_found;
  logic [3:0]     sel_op;
  logic [31:0]    sel_a, sel_b;
  logic           sel_long, sel_illegal;
  logic           accept, resp_hs;

  logic [3:0]      op_q;
  logic [31:0]     a_q, b_q;
  logic [IDW-1:0]  id_q;
  logic [CNTW-1:0] cnt;
  logic [31:0]     data_q;
  logic [4:0]      exc_q;

  // Two passes give "first valid at or above rr_ptr, else first valid below it"
  // without a variable-index select.
  always_comb begin
    cand_found = 1'b0;
    cand_id    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!cand_found && req_valid[i] && (IDW'(i) >= rr_ptr)) begin
        cand_found = 1'b1;
        cand_id    = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!cand_found && req_valid[i] && (IDW'(i) < rr_ptr)) begin
        cand_found = 1'b1;
        cand_id    = IDW'(i);
      end
    end
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (cand_id == IDW'(i)) begin
        sel_op = req_op[4*i +: 4];
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
      end
    end
  end

  assign sel_long    = (sel_op == 4'b0011) || (sel_op == 4'b0100);
  assign sel_illegal = (sel_op >= 4'b1101);
  assign accept      = (state == IDLE) && cand_found;
  assign resp_hs     = (state == RESP) && resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (cand_found) next_state = sel_illegal ? RESP : EXEC;
      EXEC: if (cnt == CNTW'(1)) next_state = RESP;
      RESP: if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (state == IDLE) && cand_found && (cand_id == IDW'(i));
    end
    resp_valid = (state == RESP);
  end

  // Illegal ops never touch the issue regs, so the FPU inputs keep the last real op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      id_q   <= '0;
      cnt    <= '0;
      data_q <= '0;
      exc_q  <= '0;
      rr_ptr <= '0;
    end else begin
      if (accept) begin
        id_q   <= cand_id;
        rr_ptr <= (cand_id == IDW'(NREQ - 1)) ? '0 : cand_id + 1'b1;
        if (sel_illegal) begin
          data_q <= '0;
          exc_q  <= 5'b10000;
        end else begin
          op_q <= sel_op;
          a_q  <= sel_a;
          b_q  <= sel_b;
          cnt  <= sel_long ? CNTW'(LAT_LONG) : CNTW'(LAT_SHORT);
        end
      end
      if (state == EXEC) begin
        cnt <= cnt - 1'b1;
        if (cnt == CNTW'(1)) begin
          data_q <= fpu_rd;
          exc_q  <= fpu_exc;
        end
      end
    end
  end

  assign fpu_op_sel = op_q;
  assign fpu_rsA    = a_q;
  assign fpu_rsB    = b_q;
  assign resp_id    = id_q;
  assign resp_data  = data_q;
  assign resp_exc   = exc_q;

`ifdef FPU_ARB_STICKY_FSR_EN
  logic [5*NREQ-1:0] fsr_q;

  // A handshake on the same cycle as a clear leaves only the new flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsr_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (resp_hs && (id_q == IDW'(i)))
          fsr_q[5*i +: 5] <= fsr_clr[i] ? exc_q : (fsr_q[5*i +: 5] | exc_q);
        else if (fsr_clr[i])
          fsr_q[5*i +: 5] <= '0;
      end
    end
  end

  assign fsr_flags = fsr_q;
`else
  logic unused_fsr_clr;
  logic unused_resp_hs;
  assign unused_fsr_clr = ^fsr_clr;
  assign unused_resp_hs = resp_hs;
  assign fsr_flags      = '0;
`endif

endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter with a small table-driven FPU model.
module tb_fpu_arbiter;

  localparam int NREQ      = 4;
  localparam int IDW       = 2;
  localparam int LAT_SHORT = 1;
  localparam int LAT_LONG  = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [4*NREQ-1:0]    req_op = '0;
  logic [32*NREQ-1:0]   req_a = '0;
  logic [32*NREQ-1:0]   req_b = '0;
  logic [3:0]           fpu_op_sel;
  logic [31:0]          fpu_rsA, fpu_rsB;
  logic [31:0]          fpu_rd;
  logic [4:0]           fpu_exc;
  logic                 resp_valid;
  logic                 resp_ready = 1'b1;
  logic [IDW-1:0]       resp_id;
  logic [31:0]          resp_data;
  logic [4:0]           resp_exc;
  logic [5*NREQ-1:0]    fsr_flags;
  logic [NREQ-1:0]      fsr_clr = '0;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [4:0]  exc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   first_cyc = 0;
  bit   in_resp  = 1'b0;

  fpu_arbiter #(
    .NREQ(NREQ), .IDW(IDW), .LAT_SHORT(LAT_SHORT), .LAT_LONG(LAT_LONG)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .fpu_op_sel(fpu_op_sel), .fpu_rsA(fpu_rsA), .fpu_rsB(fpu_rsB),
    .fpu_rd(fpu_rd), .fpu_exc(fpu_exc),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .resp_exc(resp_exc),
    .fsr_flags(fsr_flags), .fsr_clr(fsr_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Known IEEE results for the directed vectors; anything else returns A^B.
  always_comb begin
    fpu_rd  = fpu_rsA ^ fpu_rsB;
    fpu_exc = 5'b00000;
    if (fpu_op_sel == 4'b0000 && fpu_rsA == 32'h3fc00000 && fpu_rsB == 32'h40100000)
      fpu_rd = 32'h40700000;
    if (fpu_op_sel == 4'b0010 && fpu_rsA == 32'h40400000 && fpu_rsB == 32'hc0000000)
      fpu_rd = 32'hc0c00000;
    if (fpu_op_sel == 4'b0100 && fpu_rsA == 32'h41800000)
      fpu_rd = 32'h40800000;
    if (fpu_op_sel == 4'b0011 && fpu_rsB == 32'h00000000) begin
      fpu_rd  = 32'h7f800000;
      fpu_exc = 5'b01000;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: latency is measured from the accept cycle to the first resp_valid cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      in_resp = 1'b0;
    end else begin
      if (|(req_valid & req_ready)) acc_cyc = cyc;
      if (resp_valid && !in_resp) begin
        in_resp   = 1'b1;
        first_cyc = cyc;
      end
      if (resp_valid && resp_ready) begin
        in_resp = 1'b0;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_resp: got id %0d data 0x%08h, expected none", resp_id, resp_data);
        end else begin
          e = sb.pop_front();
          checkOutput("resp_id", 32'(resp_id), e.id);
          checkOutput("resp_data", resp_data, e.data);
          checkOutput("resp_exc", 32'(resp_exc), 32'(e.exc));
          checkOutput("resp_latency", first_cyc - acc_cyc, e.lat);
        end
      end
    end
  end

  task automatic applyStimulus(input int id, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input bit push, input logic [31:0] exp_data,
                               input logic [4:0] exp_exc, input int lat);
    exp_t e;
    req_op[4*id +: 4]  = op;
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_valid[id]      = 1'b1;
    if (push) begin
      e.id   = id;
      e.data = exp_data;
      e.exc  = exp_exc;
      e.lat  = lat;
      sb.push_back(e);
    end
  endtask

  task automatic waitGrant(input int id, input bit drop);
    int n = 0;
    logic [NREQ-1:0] exp_rdy;
    exp_rdy     = '0;
    exp_rdy[id] = 1'b1;
    @(negedge clk);
    while (req_ready == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_ready == '0) reportTimeout("grant");
    else checkOutput("grant", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (drop) req_valid[id] = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || resp_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || resp_valid) reportTimeout("drain");
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_req_ready", 32'(req_ready), 0);
    checkOutput("rst_fpu_op_sel", 32'(fpu_op_sel), 0);
    checkOutput("rst_fpu_rsA", fpu_rsA, 0);
    checkOutput("rst_fpu_rsB", fpu_rsB, 0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 0);
    checkOutput("rst_resp_id", 32'(resp_id), 0);
    checkOutput("rst_resp_data", resp_data, 0);
    checkOutput("rst_resp_exc", 32'(resp_exc), 0);
    checkOutput("rst_fsr_flags", 32'(fsr_flags), 0);
  endtask

  task automatic doReset();
    #3 rst = 1'b1;
    #1 checkResetOutputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    doReset();

    // Single FADD from requester 0.
    applyStimulus(0, 4'b0000, 32'h3fc00000, 32'h40100000, 1, 32'h40700000, 5'b0, LAT_SHORT + 1);
    waitGrant(0, 1);
    waitDrain();

    // SQRT from requester 2: long latency, operands held through EXEC.
    applyStimulus(2, 4'b0100, 32'h41800000, 32'h00000000, 1, 32'h40800000, 5'b0, LAT_LONG + 1);
    waitGrant(2, 1);
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 10) begin
      checkOutput("exec_fpu_rsA", fpu_rsA, 32'h41800000);
      checkOutput("exec_fpu_op_sel", 32'(fpu_op_sel), 32'h4);
      @(negedge clk);
      n++;
    end
    if (!resp_valid) reportTimeout("sqrt_resp");
    waitDrain();

    // Round-robin from a fresh pointer with all four requesters held valid.
    doReset();
    for (int i = 0; i < NREQ; i++)
      applyStimulus(i, 4'b0010, 32'h40400000, 32'hc0000000, 0, 32'h0, 5'b0, 0);
    for (int g = 0; g < 5; g++) begin
      applyStimulus(g % NREQ, 4'b0010, 32'h40400000, 32'hc0000000, 1, 32'hc0c00000, 5'b0, LAT_SHORT + 1);
      waitGrant(g % NREQ, 0);
    end
    req_valid = '0;
    waitDrain();

    // Backpressure: response held, no grants, requester 3 granted right after handshake.
    resp_ready = 1'b0;
    applyStimulus(1, 4'b0000, 32'h3fc00000, 32'h40100000, 1, 32'h40700000, 5'b0, LAT_SHORT + 1);
    applyStimulus(3, 4'b0000, 32'h00000001, 32'h00000002, 1, 32'h00000003, 5'b0, LAT_SHORT + 1);
    waitGrant(1, 1);
    n = 0;
    while (!resp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) reportTimeout("bp_resp");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp_resp_valid", 32'(resp_valid), 1);
      checkOutput("bp_resp_id", 32'(resp_id), 1);
      checkOutput("bp_resp_data", resp_data, 32'h40700000);
      checkOutput("bp_req_ready", 32'(req_ready), 0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_resume_grant", 32'(req_ready), 32'b1000);
    @(posedge clk);
    #1 req_valid[3] = 1'b0;
    waitDrain();

    // Illegal op from requester 1 bypasses the FPU.
    applyStimulus(1, 4'b1111, 32'h12345678, 32'h9abcdef0, 1, 32'h0, 5'b10000, 1);
    waitGrant(1, 1);
    waitDrain();
`ifdef FPU_ARB_STICKY_FSR_EN
    checkOutput("fsr_set", 32'(fsr_flags), 32'h00000200);
    repeat (3) @(posedge clk);
    #1 checkOutput("fsr_hold", 32'(fsr_flags), 32'h00000200);
    fsr_clr[1] = 1'b1;
    @(posedge clk);
    #1 fsr_clr[1] = 1'b0;
    checkOutput("fsr_cleared", 32'(fsr_flags), 0);
`else
    checkOutput("fsr_tied_off", 32'(fsr_flags), 0);
`endif

    // FDIV by zero completes with divide-by-zero flag.
    applyStimulus(0, 4'b0011, 32'h40c00000, 32'h00000000, 1, 32'h7f800000, 5'b01000, LAT_LONG + 1);
    waitGrant(0, 1);
    waitDrain();
`ifdef FPU_ARB_STICKY_FSR_EN
    checkOutput("fsr_div0", 32'(fsr_flags), 32'h00000008);
`endif

    // Reset during EXEC drops the op and restarts arbitration at requester 0.
    applyStimulus(1, 4'b0011, 32'h40c00000, 32'h00000000, 0, 32'h0, 5'b0, 0);
    waitGrant(1, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 checkResetOutputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1, 4'b0000, 32'h00000005, 32'h00000003, 1, 32'h00000006, 5'b0, LAT_SHORT + 1);
    applyStimulus(3, 4'b0000, 32'h00000010, 32'h00000001, 1, 32'h00000011, 5'b0, LAT_SHORT + 1);
    waitGrant(1, 1);
    waitGrant(3, 1);
    waitDrain();

    checkOutput("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
